prgrm_cnt_stk: RTL and testbench
================================

# prgrm_cnt_stk

Parametrised program counter with an integrated hardware return-address stack. It supports increment, absolute and PC-relative branch, call (push return address) and return (pop), plus a pipeline stall. It sits in the instruction-fetch stage and drives the instruction-memory address. It receives its one-hot-ish control strobes from the control unit's decode FSM, and that FSM no longer has to manage return addresses itself.

## Interface
Parameters:
- AW, 8, address width; the PC and all arithmetic are modulo 2^AW
- DEPTH, 4, return-stack entries (≥2)
- RST_VEC, 0, PC value after reset

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- stall  in  1  freeze: PC, stack and flags hold
- incr  in  1  PC ← PC+1
- ld_brnch  in  1  branch; target = imm_addr, or PC+rel_ofs when brnch_rel=1
- brnch_rel  in  1  selects relative target for ld_brnch and call
- call  in  1  push PC+1, PC ← target (same target rule as ld_brnch)
- ret  in  1  PC ← top of stack, pop
- imm_addr  in  AW  absolute target
- rel_ofs  in  AW  two's-complement signed offset
- err_clr  in  1  clears stk_ovf and stk_unf
- pc  out  AW  current PC (registered)
- stk_cnt  out  $clog2(DEPTH+1)  valid entries, 0..DEPTH
- stk_full  out  1  stk_cnt==DEPTH
- stk_empty  out  1  stk_cnt==0
- stk_ovf  out  1  sticky: a call occurred while full
- stk_unf  out  1  sticky: a ret occurred while empty

## Operation
- Priority per cycle, highest first: reset, stall, ret, call, ld_brnch, incr, hold. Only the winning action takes effect; lower strobes that cycle are ignored.
- Relative target = (PC + rel_ofs) mod 2^AW, where PC is the value of the current instruction. Sign is handled by plain AW-bit addition.
- PC+1 wraps from 2^AW−1 to 0 without any flag.
- The stack is a circular buffer of DEPTH×AW registers with a top pointer and a count.
- call, not full: write PC+1 at top+1, top advances, stk_cnt+1, PC ← target.
- call, full: PC+1 overwrites the oldest entry (circular) and becomes the new top. stk_cnt stays DEPTH. stk_ovf set. PC ← target.
- ret, not empty: PC ← entry at top, top retreats, stk_cnt−1.
- ret, empty: PC ← PC+1 (treated as a NOP), stk_unf set, stack unchanged.
- err_clr: clears both sticky flags unless the same cycle sets one; a set wins over a clear. err_clr is honoured during stall.
- Stack entry contents are not reset; only the pointer and count are reset. Reading a popped slot is never visible.

## Timing
- Reset values: pc=RST_VEC, stk_cnt=0, stk_empty=1, stk_full=0, stk_ovf=0, stk_unf=0.
- All outputs are registered or decoded directly from registers, with no input-to-output combinational path.
- Latency: a strobe sampled on edge N is reflected on pc and the stack outputs immediately after edge N. One action per cycle, back-to-back allowed.
- call followed by ret on the next cycle returns to the call's PC+1.
- reset asserted mid-sequence, including with stall=1, fully empties the stack on that edge.
- stall=1 with ret=1 on an empty stack: stk_unf is not set; stall wins.

## Test plan
All scenarios use AW=8, DEPTH=4.
- Reset/increment/wrap: reset, then incr for 3 cycles gives pc=0,1,2,3. Load pc=0xFF via ld_brnch with imm_addr=0xFF, then incr gives pc=0x00.
- Relative branch: pc=0x10, ld_brnch=1, brnch_rel=1, rel_ofs=0xFC gives pc=0x0C. From pc=0xFE with rel_ofs=0x05, pc=0x03.
- Nested call/ret: from pc=0x20, call imm_addr 0x40. Then from 0x40, call 0x60. After that stk_cnt=2. ret gives pc=0x41; ret gives pc=0x21 with stk_empty=1.
- Overflow: 5 successive calls from pc values 0x00, 0x10, 0x20, 0x30, 0x40. Result: stk_full=1 and stk_ovf=1. Four rets return 0x41, 0x31, 0x21, 0x11, with stk_ovf still 1. err_clr clears it.
- Underflow/priority: ret on an empty stack at pc=0x05 gives pc=0x06 and stk_unf=1. Asserting ret+call+incr together with a non-empty stack pops only. stall=1 with all strobes high leaves everything unchanged.
- Reset mid-operation: with stk_cnt=3 and pc=0x77, reset=1 for 1 cycle gives pc=RST_VEC, stk_cnt=0, and both flags cleared.

Source files
------------

// File: rtl/prgrm_cnt_stk_if.sv
// rtl/prgrm_cnt_stk_if.sv - control strobes and status bundle for the program counter / return stack
interface prgrm_cnt_stk_if #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          stall;
  logic          incr;
  logic          ld_brnch;
  logic          brnch_rel;
  logic          call;
  logic          ret;
  logic [AW-1:0] imm_addr;
  logic [AW-1:0] rel_ofs;
  logic          err_clr;
  logic [AW-1:0] pc;
  logic [CW-1:0] stk_cnt;
  logic          stk_full;
  logic          stk_empty;
  logic          stk_ovf;
  logic          stk_unf;

  modport master (
    output stall, incr, ld_brnch, brnch_rel, call, ret, imm_addr, rel_ofs, err_clr,
    input  pc, stk_cnt, stk_full, stk_empty, stk_ovf, stk_unf
  );

  modport slave (
    input  stall, incr, ld_brnch, brnch_rel, call, ret, imm_addr, rel_ofs, err_clr,
    output pc, stk_cnt, stk_full, stk_empty, stk_ovf, stk_unf
  );
endinterface

// File: rtl/prgrm_cnt_stk.sv
// rtl/prgrm_cnt_stk.sv - fetch-stage program counter with circular hardware return-address stack
module prgrm_cnt_stk #(
  parameter int            AW      = 8,
  parameter int            DEPTH   = 4,
  parameter logic [AW-1:0] RST_VEC = '0
) (
  input  logic           clk,
  input  logic           reset,
  prgrm_cnt_stk_if.slave bus
);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] stk_mem [DEPTH];

  logic          push, set_ovf, set_unf, full, empty;
  logic [AW-1:0] pc_inc, tgt;
  logic [PW-1:0] top_inc, top_dec;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign pc_inc  = pc_q + AW'(1);
  assign tgt     = bus.brnch_rel ? (pc_q + bus.rel_ofs) : bus.imm_addr;
  assign top_inc = (top_q == PTR_LAST) ? '0 : (top_q + PW'(1));
  assign top_dec = (top_q == '0) ? PTR_LAST : (top_q - PW'(1));

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (!bus.stall) begin
      if (bus.ret) begin
        if (empty) begin
          pc_d    = pc_inc;
          set_unf = 1'b1;
        end else begin
          pc_d  = stk_mem[top_q];
          top_d = top_dec;
          cnt_d = cnt_q - CW'(1);
        end
      end else if (bus.call) begin
        // When full, top+1 is the oldest slot, so the same write overwrites it.
        pc_d  = tgt;
        push  = 1'b1;
        top_d = top_inc;
        if (full) set_ovf = 1'b1;
        else      cnt_d   = cnt_q + CW'(1);
      end else if (bus.ld_brnch) begin
        pc_d = tgt;
      end else if (bus.incr) begin
        pc_d = pc_inc;
      end
    end
    ovf_d = set_ovf | (ovf_q & ~bus.err_clr);
    unf_d = set_unf | (unf_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RST_VEC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage is deliberately unreset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push && !reset) stk_mem[top_inc] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.stk_cnt   = cnt_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;
endmodule

// File: tb/tb_prgrm_cnt_stk.sv
// tb/tb_prgrm_cnt_stk.sv - table-driven bench for prgrm_cnt_stk
module tb_prgrm_cnt_stk;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  localparam logic [7:0] R = 8'h80, S = 8'h40, I = 8'h20, L = 8'h10;
  localparam logic [7:0] B = 8'h08, C = 8'h04, T = 8'h02, E = 8'h01;

  typedef struct {
    logic [7:0] ctl;
    logic [7:0] imm;
    logic [7:0] ofs;
    logic [7:0] pc;
    logic [2:0] cnt;
    logic [3:0] flg;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  prgrm_cnt_stk_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  prgrm_cnt_stk #(.AW(AW), .DEPTH(DEPTH), .RST_VEC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic [7:0] ctl, input logic [7:0] imm, input logic [7:0] ofs,
                              input logic [7:0] pc, input logic [2:0] cnt, input logic [3:0] flg);
    vec_t v;
    v.ctl = ctl; v.imm = imm; v.ofs = ofs; v.pc = pc; v.cnt = cnt; v.flg = flg;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset         = v.ctl[7];
    bus.stall     = v.ctl[6];
    bus.incr      = v.ctl[5];
    bus.ld_brnch  = v.ctl[4];
    bus.brnch_rel = v.ctl[3];
    bus.call      = v.ctl[2];
    bus.ret       = v.ctl[1];
    bus.err_clr   = v.ctl[0];
    bus.imm_addr  = v.imm;
    bus.rel_ofs   = v.ofs;
    @(posedge clk);
    #1;
    chk("pc",        idx, bus.pc, v.pc);
    chk("stk_cnt",   idx, {5'd0, bus.stk_cnt}, {5'd0, v.cnt});
    chk("stk_full",  idx, {7'd0, bus.stk_full}, {7'd0, v.flg[3]});
    chk("stk_empty", idx, {7'd0, bus.stk_empty}, {7'd0, v.flg[2]});
    chk("stk_ovf",   idx, {7'd0, bus.stk_ovf}, {7'd0, v.flg[1]});
    chk("stk_unf",   idx, {7'd0, bus.stk_unf}, {7'd0, v.flg[0]});
  endtask

  initial begin
    vec_t v;
    int   n;
    logic [7:0] p;
    logic [2:0] c;

    reset = 1'b1;
    bus.stall = 0; bus.incr = 0; bus.ld_brnch = 0; bus.brnch_rel = 0;
    bus.call = 0; bus.ret = 0; bus.err_clr = 0; bus.imm_addr = 0; bus.rel_ofs = 0;

    // flg = {full, empty, ovf, unf}
    tbl.push_back(mk(R,           8'h00, 8'h00, 8'h00, 3'd0, 4'b0100));
    tbl.push_back(mk(I,           8'h00, 8'h00, 8'h01, 3'd0, 4'b0100));
    tbl.push_back(mk(I,           8'h00, 8'h00, 8'h02, 3'd0, 4'b0100));
    tbl.push_back(mk(I,           8'h00, 8'h00, 8'h03, 3'd0, 4'b0100));
    tbl.push_back(mk(L,           8'hFF, 8'h00, 8'hFF, 3'd0, 4'b0100));
    tbl.push_back(mk(I,           8'h00, 8'h00, 8'h00, 3'd0, 4'b0100));
    tbl.push_back(mk(L,           8'h10, 8'h00, 8'h10, 3'd0, 4'b0100));
    tbl.push_back(mk(L|B,         8'hAA, 8'hFC, 8'h0C, 3'd0, 4'b0100));
    tbl.push_back(mk(L,           8'hFE, 8'h00, 8'hFE, 3'd0, 4'b0100));
    tbl.push_back(mk(L|B,         8'hAA, 8'h05, 8'h03, 3'd0, 4'b0100));
    tbl.push_back(mk(L,           8'h20, 8'h00, 8'h20, 3'd0, 4'b0100));
    tbl.push_back(mk(C,           8'h40, 8'h00, 8'h40, 3'd1, 4'b0000));
    tbl.push_back(mk(C,           8'h60, 8'h00, 8'h60, 3'd2, 4'b0000));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h41, 3'd1, 4'b0000));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h21, 3'd0, 4'b0100));
    tbl.push_back(mk(L,           8'h00, 8'h00, 8'h00, 3'd0, 4'b0100));
    tbl.push_back(mk(C,           8'h10, 8'h00, 8'h10, 3'd1, 4'b0000));
    tbl.push_back(mk(C,           8'h20, 8'h00, 8'h20, 3'd2, 4'b0000));
    tbl.push_back(mk(C,           8'h30, 8'h00, 8'h30, 3'd3, 4'b0000));
    tbl.push_back(mk(C,           8'h40, 8'h00, 8'h40, 3'd4, 4'b1000));
    tbl.push_back(mk(C,           8'h50, 8'h00, 8'h50, 3'd4, 4'b1010));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h41, 3'd3, 4'b0010));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h31, 3'd2, 4'b0010));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h21, 3'd1, 4'b0010));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h11, 3'd0, 4'b0110));
    tbl.push_back(mk(E,           8'h00, 8'h00, 8'h11, 3'd0, 4'b0100));
    tbl.push_back(mk(C|B,         8'h99, 8'h10, 8'h21, 3'd1, 4'b0000));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h12, 3'd0, 4'b0100));
    tbl.push_back(mk(L,           8'h05, 8'h00, 8'h05, 3'd0, 4'b0100));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h06, 3'd0, 4'b0101));
    tbl.push_back(mk(T|E,         8'h00, 8'h00, 8'h07, 3'd0, 4'b0101));
    tbl.push_back(mk(E,           8'h00, 8'h00, 8'h07, 3'd0, 4'b0100));
    tbl.push_back(mk(C,           8'h80, 8'h00, 8'h80, 3'd1, 4'b0000));
    tbl.push_back(mk(T|C|I|L,     8'h99, 8'h00, 8'h08, 3'd0, 4'b0100));
    tbl.push_back(mk(C|L|I,       8'h30, 8'h00, 8'h30, 3'd1, 4'b0000));
    tbl.push_back(mk(L|I,         8'h44, 8'h00, 8'h44, 3'd1, 4'b0000));
    tbl.push_back(mk(S|I|L|B|C|T, 8'h55, 8'h07, 8'h44, 3'd1, 4'b0000));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h09, 3'd0, 4'b0100));
    tbl.push_back(mk(S|T,         8'h00, 8'h00, 8'h09, 3'd0, 4'b0100));
    tbl.push_back(mk(C,           8'h70, 8'h00, 8'h70, 3'd1, 4'b0000));
    tbl.push_back(mk(C,           8'h71, 8'h00, 8'h71, 3'd2, 4'b0000));
    tbl.push_back(mk(C,           8'h76, 8'h00, 8'h76, 3'd3, 4'b0000));
    tbl.push_back(mk(I,           8'h00, 8'h00, 8'h77, 3'd3, 4'b0000));
    tbl.push_back(mk(R|S|C,       8'h12, 8'h00, 8'h00, 3'd0, 4'b0100));
    tbl.push_back(mk(T,           8'h00, 8'h00, 8'h01, 3'd0, 4'b0101));
    tbl.push_back(mk(R,           8'h00, 8'h00, 8'h00, 3'd0, 4'b0100));

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    n = tbl.size();

    // Overflow, stall with err_clr, overflow again, then reset clears it.
    for (int i = 0; i < 5; i++) begin
      p = 8'((i + 1) * 16);
      c = (i < 4) ? 3'(i + 1) : 3'd4;
      v = mk(C, p, 8'h00, p, c, {(i >= 3), 1'b0, (i == 4), 1'b0});
      apply(v, n++);
    end
    apply(mk(S|T|C|E, 8'hEE, 8'h00, 8'h50, 3'd4, 4'b1000), n++);
    apply(mk(C,       8'h60, 8'h00, 8'h60, 3'd4, 4'b1010), n++);
    apply(mk(T,       8'h00, 8'h00, 8'h51, 3'd3, 4'b0010), n++);
    apply(mk(T,       8'h00, 8'h00, 8'h41, 3'd2, 4'b0010), n++);
    apply(mk(R,       8'h00, 8'h00, 8'h00, 3'd0, 4'b0100), n++);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
